im_loader: RTL and testbench

- Write side of the 4 KB instruction memory: receives a byte stream, assembles big-endian 32-bit words, and writes them sequentially from word 0.
- Also provides the combinational instruction read port used by the CPU fetch path (pc -> instruction).
- Holds the CPU in reset through cpu_reset_n while a program image is loading, and releases it once loading is complete.

---
 rtl/im_loader_if.sv | 14 +
 rtl/im_loader.sv | 120 ++++++++++++
 tb/tb_im_loader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/im_loader_if.sv
// Load-control and byte-stream bundle between a program-image source and im_loader.
// The source drives the request and the bytes; the loader answers with in_ready.
interface im_loader_if #(
  parameter int LEN_W = 11
);
  logic             load_start;
  logic [LEN_W-1:0] load_len;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;

  modport master (output load_start, load_len, in_valid, in_data, input in_ready);
  modport slave  (input load_start, load_len, in_valid, in_data, output in_ready);
endinterface

// File: rtl/im_loader.sv
// Instruction-memory loader: packs a big-endian byte stream into 32-bit words written from
// word 0, holds the CPU in reset while loading, and serves the combinational fetch port.
module im_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic        clock,
  input  logic        reset,
  im_loader_if.slave  ld,
  output logic        busy,
  output logic        load_done,
  output logic        error,
  output logic        cpu_reset_n,
  input  logic [31:0] pc,
  output logic [31:0] instruction
);

  localparam int LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] word_addr_q, word_addr_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic              error_q, error_d;
  logic              cpu_reset_n_q, cpu_reset_n_d;

  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [LEN_W-1:0]  len_m1;
  logic [31:0]       mem [DEPTH];

  assign len_m1 = ld.load_len - LEN_W'(1);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    word_addr_d = word_addr_q;
    last_addr_d = last_addr_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    error_d     = error_q;
    mem_we      = 1'b0;
    mem_wdata   = {shift_q, ld.in_data};

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (ld.load_start) begin
          if (ld.load_len > LEN_W'(DEPTH)) begin
            error_d = 1'b1;
          end else if (ld.load_len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_LOAD;
            last_addr_d = len_m1[ADDR_W-1:0];
            word_addr_d = '0;
            byte_cnt_d  = '0;
            shift_d     = '0;
          end
        end
      end
      S_LOAD: begin
        if (ld.in_valid) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          shift_d    = {shift_q[15:0], ld.in_data};
          // The fourth byte completes the word; the first three already sit in shift_q.
          if (byte_cnt_q == 2'd3) begin
            mem_we      = 1'b1;
            word_addr_d = word_addr_q + ADDR_W'(1);
            if (word_addr_q == last_addr_q) state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    cpu_reset_n_d = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      word_addr_q   <= '0;
      last_addr_q   <= '0;
      byte_cnt_q    <= '0;
      shift_q       <= '0;
      error_q       <= 1'b0;
      cpu_reset_n_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_addr_q   <= word_addr_d;
      last_addr_q   <= last_addr_d;
      byte_cnt_q    <= byte_cnt_d;
      shift_q       <= shift_d;
      error_q       <= error_d;
      cpu_reset_n_q <= cpu_reset_n_d;
    end
  end

  // NOTE: the memory array has no reset; a loaded image must survive a reset of the loader.
  always_ff @(posedge clock) begin
    if (mem_we) mem[word_addr_q] <= mem_wdata;
  end

  assign instruction = mem[pc[ADDR_W+1:2]];

  assign ld.in_ready = (state_q == S_LOAD);
  assign busy        = (state_q == S_LOAD);
  assign load_done   = (state_q == S_DONE);
  assign error       = error_q;
  assign cpu_reset_n = cpu_reset_n_q;

  // Byte offset and the region bits above the 4 KB window play no part in the fetch.
  logic unused_pc;
  assign unused_pc = ^{pc[31:ADDR_W+2], pc[1:0]};

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: directed boot scenarios plus randomized loads,
// compared against a word-array model built from the byte stream.
module tb_im_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        busy, load_done, error, cpu_reset_n;
  logic [31:0] pc;
  logic [31:0] instruction;

  always #5 clock = ~clock;

  im_loader_if #(.LEN_W(11)) bus ();

  im_loader dut (
    .clock       (clock),
    .reset       (reset),
    .ld          (bus),
    .busy        (busy),
    .load_done   (load_done),
    .error       (error),
    .cpu_reset_n (cpu_reset_n),
    .pc          (pc),
    .instruction (instruction)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          busy_total = 0;
  int          gap_total;
  int          mark;
  logic [31:0] model_mem [1024];
  bit          known [1024];
  logic [7:0]  tx_q [$];

  // Counts edges at which the loader was busy beforehand, i.e. cycles spent in LOAD.
  always @(posedge clock) if (busy) busy_total++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_load(input int len);
    bus.load_start = 1'b1;
    bus.load_len   = 11'(len);
    step();
    bus.load_start = 1'b0;
    bus.load_len   = '0;
  endtask

  // Sends every byte of tx_q; gap idle cycles precede each byte after the first.
  task automatic stream(input int gap, input bit rand_gap);
    int g;
    int n;
    gap_total = 0;
    foreach (tx_q[k]) begin
      g = (k == 0) ? 0 : (rand_gap ? int'($urandom_range(gap, 0)) : gap);
      gap_total += g;
      bus.in_valid = 1'b0;
      repeat (g) step();
      n = 0;
      while (!bus.in_ready && n < 20) begin
        step();
        n++;
      end
      if (!bus.in_ready) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = tx_q[k];
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  // Reference: word i of the image is bytes 4i..4i+3, most significant first; only whole words land.
  task automatic model_commit(input int len);
    for (int i = 0; i < len; i++) begin
      if (4 * i + 3 < tx_q.size()) begin
        model_mem[i] = {tx_q[4*i], tx_q[4*i+1], tx_q[4*i+2], tx_q[4*i+3]};
        known[i]     = 1'b1;
      end
    end
  endtask

  task automatic read_at(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    pc = addr;
    #1;
    check(tag, instruction, exp);
  endtask

  // Reads every word the model knows through a pc with random high and low bits.
  task automatic check_mem(input string tag);
    logic [31:0] r;
    for (int i = 0; i < 1024; i++) begin
      if (known[i]) begin
        r  = $urandom();
        pc = {r[31:12], 10'(i), r[1:0]};
        #1;
        check(tag, instruction, model_mem[i]);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_load_done"}, 32'(load_done), 32'd0);
    check({tag, "_cpu_reset_n"}, 32'(cpu_reset_n), 32'd0);
  endtask

  task automatic check_done(input string tag);
    check({tag, "_load_done"}, 32'(load_done), 32'd1);
    check({tag, "_cpu_reset_n"}, 32'(cpu_reset_n), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    bus.load_start = 1'b0;
    bus.load_len   = '0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    pc             = '0;
    foreach (known[i]) known[i] = 1'b0;

    // Reset state
    reset = 1'b0;
    step();
    step();
    check_idle("rst");
    check("rst_error", 32'(error), 32'd0);
    reset = 1'b1;
    step();
    check_idle("post_rst");

    // Two-word load, back-to-back bytes
    tx_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h22, 8'h18, 8'h20};
    start_load(2);
    check("s2_busy", 32'(busy), 32'd1);
    check("s2_cpu_reset_n_load", 32'(cpu_reset_n), 32'd0);
    mark = busy_total;
    stream(0, 1'b0);
    check("s2_busy_cycles", 32'(busy_total - mark), 32'd8);
    check_done("s2");
    model_commit(2);
    read_at("s2_pc3004", 32'h0000_3004, 32'h0022_1820);
    read_at("s2_pc3000", 32'h0000_3000, 32'h2008_0005);
    check_mem("s2_mem");

    // Same load from DONE with three idle cycles between bytes
    start_load(2);
    check("s3_cpu_reset_n_load", 32'(cpu_reset_n), 32'd0);
    mark = busy_total;
    stream(3, 1'b0);
    check("s3_busy_cycles", 32'(busy_total - mark), 32'd29);
    check_done("s3");
    check_mem("s3_mem");

    // Reset after six of eight bytes
    tx_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h11, 8'h22};
    start_load(2);
    stream(0, 1'b0);
    check("s5_still_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check_idle("s5_rst");
    model_commit(2);
    step();
    reset = 1'b1;
    step();
    check_idle("s5_idle");
    read_at("s5_mem0", 32'h0000_3000, 32'h2008_0005);
    read_at("s5_mem1", 32'h0000_3004, 32'h0022_1820);

    // Zero-length and oversize requests
    start_load(0);
    check_done("s4_len0");
    check("s4_error_clear", 32'(error), 32'd0);
    check_mem("s4_mem_len0");
    start_load(1025);
    check("s4_error_set", 32'(error), 32'd1);
    check_done("s4_len1025");
    check_mem("s4_mem_len1025");

    // Reload of one word from DONE
    tx_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    start_load(1);
    check("s6_cpu_reset_n_load", 32'(cpu_reset_n), 32'd0);
    check("s6_busy", 32'(busy), 32'd1);
    stream(2, 1'b1);
    check_done("s6");
    model_commit(1);
    read_at("s6_pc3000", 32'h0000_3000, 32'hAABB_CCDD);
    check("s6_error_sticky", 32'(error), 32'd1);

    // Randomized loads with random idle gaps
    for (int t = 0; t < 6; t++) begin
      len  = int'($urandom_range(8, 1));
      tx_q = {};
      for (int b = 0; b < 4 * len; b++) tx_q.push_back(8'($urandom()));
      start_load(len);
      mark = busy_total;
      stream(3, 1'b1);
      check("rnd_busy_cycles", 32'(busy_total - mark), 32'(4 * len + gap_total));
      check_done("rnd");
      model_commit(len);
      check_mem("rnd_mem");
    end

    // Full-depth load reaches the last word without wrapping
    tx_q = {};
    for (int b = 0; b < 4096; b++) tx_q.push_back(8'($urandom()));
    start_load(1024);
    mark = busy_total;
    stream(0, 1'b0);
    check("full_busy_cycles", 32'(busy_total - mark), 32'd4096);
    check_done("full");
    model_commit(1024);
    check_mem("full_mem");
    check("full_error_sticky", 32'(error), 32'd1);

    // Only reset clears error
    reset = 1'b0;
    #1;
    check("final_error_cleared", 32'(error), 32'd0);
    check_idle("final_rst");
    reset = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
